// File: rtl/nrz_tx_pkg.sv
// Shared types and constants for the NRZ test-pattern transmitter.
package nrz_tx_pkg;

  localparam int PERIOD_W   = 16;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA
  } tx_state_e;

  // A bit shorter than two cycles could not carry a separate strobe and level.
  function automatic logic [PERIOD_W-1:0] clampPeriod(input logic [PERIOD_W-1:0] p);
    return (p < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : p;
  endfunction

endpackage

// File: rtl/nrz_bit_tx_bit_timer.sv
// Bit-period timer: latches the period on restart and pulses tick_o on the last cycle of each bit.
module bit_timer
  import nrz_tx_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                restart_i,
  input  logic [PERIOD_W-1:0] per_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] per_q;

  assign tick_o = (cnt_q == (per_q - PERIOD_W'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      per_q <= PERIOD_W'(MIN_PERIOD);
    end else if (restart_i) begin
      cnt_q <= '0;
      per_q <= per_i;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/nrz_bit_tx.sv
// NRZ pattern transmitter: 1010 preamble followed by MSB-first bytes, with a bit strobe reference.
module nrz_bit_tx
  import nrz_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   PRE_LEN    = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                clk_300M,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                signal_out,
  output logic                bit_strobe,
  output logic                busy
);

  localparam int IDX_MAX = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
  localparam int IDX_W   = $clog2(IDX_MAX);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             holdFull_q, holdFull_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] bitIdx_q, bitIdx_d;
  logic             signal_q, signal_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             restart;
  logic             tick;
  logic             load;
  logic             handshake;

  bit_timer u_bit_timer (
    .clk_i    (clk_300M),
    .rst_i    (rst),
    .restart_i(restart),
    .per_i    (clampPeriod(bit_period)),
    .tick_o   (tick)
  );

  assign handshake = data_valid && ready_q;

  // Every output is computed one cycle ahead so signal_out and bit_strobe switch on the same edge.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    shift_d    = shift_q;
    bitIdx_d   = bitIdx_q;
    signal_d   = signal_q;
    strobe_d   = 1'b0;
    restart    = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        signal_d = IDLE_LEVEL;
        if (holdFull_q) begin
          restart  = 1'b1;
          state_d  = PREAMBLE;
          bitIdx_d = '0;
          signal_d = 1'b1;
          strobe_d = 1'b1;
        end
      end
      PREAMBLE: begin
        if (tick) begin
          strobe_d = 1'b1;
          if (bitIdx_q == IDX_W'(PRE_LEN - 1)) begin
            state_d = DATA;
            load    = 1'b1;
          end else begin
            bitIdx_d = bitIdx_q + IDX_W'(1);
            signal_d = ~bitIdx_d[0];
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (bitIdx_q == IDX_W'(WIDTH - 1)) begin
            if (holdFull_q) begin
              load     = 1'b1;
              strobe_d = 1'b1;
            end else begin
              state_d  = IDLE;
              signal_d = IDLE_LEVEL;
            end
          end else begin
            bitIdx_d = bitIdx_q + IDX_W'(1);
            shift_d  = shift_q << 1;
            signal_d = shift_d[WIDTH-1];
            strobe_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        signal_d = IDLE_LEVEL;
      end
    endcase

    // Handshake and load are mutually exclusive because ready is low whenever hold is full.
    if (load) begin
      shift_d    = hold_q;
      bitIdx_d   = '0;
      signal_d   = hold_q[WIDTH-1];
      holdFull_d = 1'b0;
    end
    if (handshake) begin
      hold_d     = data_in;
      holdFull_d = 1'b1;
    end

    busy_d  = (state_d != IDLE);
    ready_d = !holdFull_d;
  end

  always_ff @(posedge clk_300M) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      shift_q    <= '0;
      bitIdx_q   <= '0;
      signal_q   <= IDLE_LEVEL;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      shift_q    <= shift_d;
      bitIdx_q   <= bitIdx_d;
      signal_q   <= signal_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign data_ready = ready_q;
  assign signal_out = signal_q;
  assign bit_strobe = strobe_q;
  assign busy       = busy_q;

endmodule
